// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU sequencer: opcodes and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_sequencer_if.sv
// Command (two requesters) and response channels of the ALU sequencer.
interface alu_rr_sequencer_if #(parameter int DW = 4) ();

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2:0]      req0_op;
  logic [DW-1:0]   req0_a;
  logic [DW-1:0]   req0_b;
  logic [2:0]      req1_op;
  logic [DW-1:0]   req1_a;
  logic [DW-1:0]   req1_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [2*DW-1:0] rsp_result;
  logic            rsp_err;

  modport master (
    output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: operands zero-extended to 2*DW, err on div-by-zero or illegal op.
module alu_core
  import alu_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [2:0]      op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] result,
  output logic            err
);

  logic [2*DW-1:0] ax;
  logic [2*DW-1:0] bx;

  assign ax = {{DW{1'b0}}, a};
  assign bx = {{DW{1'b0}}, b};

  // Opcode decode and arithmetic
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_ADD: result = ax + bx;
      OP_SUB: result = ax - bx;
      OP_MUL: result = ax * bx;
      OP_DIV: begin
        if (bx == '0) begin
          result = '1;
          err    = 1'b1;
        end else begin
          result = ax / bx;
        end
      end
      OP_AND: result = ax & bx;
      OP_OR:  result = ax | bx;
      default: begin
        result = '0;
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Round-robin arbiter feeding one registered ALU; IDLE -> EXEC -> RESP per command.
module alu_rr_sequencer
  import alu_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_rr_sequencer_if.slave bus
);

  state_t          state;
  state_t          next_state;
  logic            last_grant;
  logic            grant;
  logic            any_valid;
  logic [1:0]      req_ready;

  logic            id_q;
  logic [2:0]      op_q;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;

  logic            rsp_id_q;
  logic [2*DW-1:0] rsp_result_q;
  logic            rsp_err_q;

  logic [2*DW-1:0] core_result;
  logic            core_err;

  assign any_valid = |bus.req_valid;

  // Grant: sole requester wins, on a tie the one not served last
  always_comb begin
    if (&bus.req_valid) grant = ~last_grant;
    else                grant = bus.req_valid[1];
  end

  // Next-state and command-accept decode
  always_comb begin
    next_state = state;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (any_valid && !rst) begin
          req_ready[grant] = 1'b1;
          next_state       = EXEC;
        end
      end
      EXEC: next_state = RESP;
      RESP: if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Command latch on accept, result capture in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (state == IDLE && any_valid) begin
        id_q       <= grant;
        last_grant <= grant;
        op_q       <= grant ? bus.req1_op : bus.req0_op;
        a_q        <= grant ? bus.req1_a  : bus.req0_a;
        b_q        <= grant ? bus.req1_b  : bus.req0_b;
      end
      if (state == EXEC) begin
        rsp_id_q     <= id_q;
        rsp_result_q <= core_result;
        rsp_err_q    <= core_err;
      end
    end
  end

  alu_core #(.DW(DW)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_result),
    .err    (core_err)
  );

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a response scoreboard.
module tb_alu_rr_sequencer;

  localparam int DW = 4;

  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_rr_sequencer_if #(.DW(DW)) bus ();

  alu_rr_sequencer #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  exp_t        sb[$];
  logic        lg_m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int unsigned x;
    int unsigned y;
    int unsigned r;
    logic        e;
    x = a;
    y = b;
    r = 0;
    e = 1'b0;
    case (op)
      3'd0: r = x + y;
      3'd1: r = (x + 256 - y) % 256;
      3'd2: r = x * y;
      3'd3: if (y == 0) begin r = 255; e = 1'b1; end else r = x / y;
      3'd4: r = x & y;
      3'd5: r = x | y;
      default: begin r = 0; e = 1'b1; end
    endcase
    return {e, r[7:0]};
  endfunction

  task automatic set_ops(input logic [2:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [2:0] o1, input logic [3:0] a1, input logic [3:0] b1);
    bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1;
  endtask

  // One command: accept in IDLE, EXEC, then RESP held for stall extra cycles
  task automatic run_op(input logic [1:0] v, input int unsigned stall);
    logic       g;
    logic [8:0] m;
    exp_t       e;
    @(negedge clk);
    bus.req_valid = v;
    bus.rsp_ready = 1'b0;
    #1;
    chk("idle_rsp_valid", 16'(bus.rsp_valid), 16'h0);
    g = (v == 2'b11) ? ~lg_m : v[1];
    chk("grant", 16'(bus.req_ready), g ? 16'h2 : 16'h1);
    m = g ? model(bus.req1_op, bus.req1_a, bus.req1_b)
          : model(bus.req0_op, bus.req0_a, bus.req0_b);
    sb.push_back('{id: g, res: m[7:0], err: m[8]});
    lg_m = g;
    @(negedge clk);
    chk("exec_rsp_valid", 16'(bus.rsp_valid), 16'h0);
    chk("exec_req_ready", 16'(bus.req_ready), 16'h0);
    @(negedge clk);
    e = sb.pop_front();
    for (int unsigned i = 0; i <= stall; i++) begin
      if (i > 0) @(negedge clk);
      chk("rsp_valid",      16'(bus.rsp_valid),  16'h1);
      chk("rsp_id",         16'(bus.rsp_id),     16'(e.id));
      chk("rsp_result",     16'(bus.rsp_result), 16'(e.res));
      chk("rsp_err",        16'(bus.rsp_err),    16'(e.err));
      chk("resp_req_ready", 16'(bus.req_ready),  16'h0);
    end
    bus.rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid",  16'(bus.rsp_valid),  16'h0);
    chk("rst_rsp_id",     16'(bus.rsp_id),     16'h0);
    chk("rst_rsp_result", 16'(bus.rsp_result), 16'h0);
    chk("rst_rsp_err",    16'(bus.rsp_err),    16'h0);
    chk("rst_req_ready",  16'(bus.req_ready),  16'h0);
    rst = 1'b0;
    bus.req_valid = 2'b00;
    lg_m = 1'b1;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    set_ops(3'd0, 4'd0, 4'd0, 3'd0, 4'd0, 4'd0);
    lg_m = 1'b1;

    do_reset();

    // single add from requester 0
    set_ops(3'b000, 4'd7, 4'd9, 3'b000, 4'd0, 4'd0);
    run_op(2'b01, 0);

    // tie from reset: grants alternate 0,1,0,1
    do_reset();
    set_ops(3'b010, 4'd15, 4'd15, 3'b001, 4'd3, 4'd5);
    for (int k = 0; k < 4; k++) run_op(2'b11, 0);

    // divide by zero and normal divide on requester 1
    set_ops(3'b000, 4'd0, 4'd0, 3'b011, 4'd9, 4'd0);
    run_op(2'b10, 0);
    set_ops(3'b000, 4'd0, 4'd0, 3'b011, 4'd9, 4'd2);
    run_op(2'b10, 0);

    // illegal opcode, plus AND/OR
    set_ops(3'b110, 4'd5, 4'd5, 3'b000, 4'd0, 4'd0);
    run_op(2'b01, 0);
    set_ops(3'b100, 4'd12, 4'd10, 3'b101, 4'd12, 4'd3);
    run_op(2'b01, 0);
    run_op(2'b10, 0);

    // backpressure with both requesting, then the other requester wins
    set_ops(3'b001, 4'd2, 4'd9, 3'b010, 4'd6, 4'd7);
    run_op(2'b11, 5);
    run_op(2'b11, 0);

    // reset during EXEC discards the in-flight add
    @(negedge clk);
    set_ops(3'b000, 4'd3, 4'd4, 3'b000, 4'd1, 4'd1);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    #1;
    chk("mid_grant", 16'(bus.req_ready), 16'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rsp_valid",  16'(bus.rsp_valid),  16'h0);
    chk("mid_req_ready",  16'(bus.req_ready),  16'h0);
    chk("mid_rsp_result", 16'(bus.rsp_result), 16'h0);
    rst = 1'b0;
    bus.req_valid = 2'b00;
    lg_m = 1'b1;
    sb.delete();
    set_ops(3'b000, 4'd8, 4'd8, 3'b001, 4'd1, 4'd2);
    run_op(2'b11, 0);

    // randomised mix
    for (int k = 0; k < 8; k++) begin
      set_ops(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      run_op(2'($urandom_range(1, 3)), $urandom_range(0, 2));
    end

    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("final_rsp_valid", 16'(bus.rsp_valid), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
